// File: rtl/rf_port_arbiter.sv
// Two-requester front end for a 32x8 register file: clears every register after reset,
// then shares one write port and two async read ports between requesters A and B.
module rf_port_arbiter #(
    parameter int                 DATA_W   = 8,
    parameter int                 ADDR_W   = 5,
    parameter int                 NREGS    = 32,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              A_REQ,
    input  logic              A_WE,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_WDATA,
    output logic              A_GNT,
    output logic              A_RVALID,
    output logic [DATA_W-1:0] A_RDATA,
    input  logic              B_REQ,
    input  logic              B_WE,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_WDATA,
    output logic              B_GNT,
    output logic              B_RVALID,
    output logic [DATA_W-1:0] B_RDATA,
    output logic              INIT_DONE,
    output logic [DATA_W-1:0] RF_DIN,
    output logic [ADDR_W-1:0] RF_ADRX,
    output logic [ADDR_W-1:0] RF_ADRY,
    output logic              RF_WR,
    input  logic [DATA_W-1:0] RF_DX,
    input  logic [DATA_W-1:0] RF_DY
);

    // One spare counter bit so NREGS == 2**ADDR_W ends the sweep without wrapping.
    localparam int               CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NREGS - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rr_q, rr_d;          // 0: A wins next write/write conflict
    logic                init_done_q, init_done_d;
    logic                a_rvalid_q, a_rvalid_d;
    logic                b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;

    logic                a_gnt, b_gnt, both_wr;
    logic                a_use_y, b_use_y;
    logic                wr;
    logic [ADDR_W-1:0]   adrx, adry;
    logic [DATA_W-1:0]   din;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        init_done_d = init_done_q;
        a_rvalid_d  = 1'b0;
        b_rvalid_d  = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        a_gnt       = 1'b0;
        b_gnt       = 1'b0;
        both_wr     = 1'b0;
        a_use_y     = 1'b0;
        b_use_y     = 1'b0;
        wr          = 1'b0;
        adrx        = '0;
        adry        = '0;
        din         = '0;

        case (state_q)
            ST_INIT: begin
                wr    = 1'b1;
                adrx  = cnt_q[ADDR_W-1:0];
                din   = INIT_VAL;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end

            ST_RUN: begin
                both_wr = A_REQ & A_WE & B_REQ & B_WE;
                a_gnt   = A_REQ & ~(both_wr & rr_q);
                b_gnt   = B_REQ & ~(both_wr & ~rr_q);
                if (both_wr) begin
                    rr_d = ~rr_q;
                end

                if (a_gnt && A_WE) begin
                    wr   = 1'b1;
                    adrx = A_ADDR;
                    din  = A_WDATA;
                end else if (b_gnt && B_WE) begin
                    wr   = 1'b1;
                    adrx = B_ADDR;
                    din  = B_WDATA;
                end

                // A reader moves to the Y port whenever the other requester owns X.
                if (a_gnt && !A_WE) begin
                    a_use_y    = b_gnt & B_WE;
                    a_rvalid_d = 1'b1;
                    if (a_use_y) begin
                        adry      = A_ADDR;
                        a_rdata_d = RF_DY;
                    end else begin
                        adrx      = A_ADDR;
                        a_rdata_d = RF_DX;
                    end
                end

                if (b_gnt && !B_WE) begin
                    b_use_y    = a_gnt;
                    b_rvalid_d = 1'b1;
                    if (b_use_y) begin
                        adry      = B_ADDR;
                        b_rdata_d = RF_DY;
                    end else begin
                        adrx      = B_ADDR;
                        b_rdata_d = RF_DX;
                    end
                end
            end

            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            rr_q        <= 1'b0;
            init_done_q <= 1'b0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            init_done_q <= init_done_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    // The sweep drives the file combinationally, so hold the bus quiet while reset is asserted.
    assign RF_WR     = wr & RST_N;
    assign RF_ADRX   = RST_N ? adrx : '0;
    assign RF_ADRY   = RST_N ? adry : '0;
    assign RF_DIN    = RST_N ? din  : '0;
    assign A_GNT     = a_gnt;
    assign B_GNT     = b_gnt;
    assign A_RVALID  = a_rvalid_q;
    assign B_RVALID  = b_rvalid_q;
    assign A_RDATA   = a_rdata_q;
    assign B_RDATA   = b_rdata_q;
    assign INIT_DONE = init_done_q;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Bench for rf_port_arbiter: behavioural register file, directed scenarios and a
// randomized two-requester run checked against a spec-level memory/arbitration model.
module tb_rf_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          CLK;
    logic          RST_N;
    logic          A_REQ, A_WE, B_REQ, B_WE;
    logic [AW-1:0] A_ADDR, B_ADDR;
    logic [DW-1:0] A_WDATA, B_WDATA;
    logic          A_GNT, A_RVALID, B_GNT, B_RVALID, INIT_DONE, RF_WR;
    logic [DW-1:0] A_RDATA, B_RDATA, RF_DIN, RF_DX, RF_DY;
    logic [AW-1:0] RF_ADRX, RF_ADRY;

    int n_cmp = 0;
    int n_err = 0;

    rf_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR), .INIT_VAL(8'h00)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
        .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
        .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA),
        .INIT_DONE(INIT_DONE), .RF_DIN(RF_DIN), .RF_ADRX(RF_ADRX), .RF_ADRY(RF_ADRY),
        .RF_WR(RF_WR), .RF_DX(RF_DX), .RF_DY(RF_DY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file: async reads, write on rising edge; contents scrambled during reset
    // so the sweep has real work to do.
    logic [DW-1:0] rf_mem [NR];
    always @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < NR; i++) rf_mem[i] <= 8'($urandom_range(1, 255));
        end else if (RF_WR) begin
            rf_mem[RF_ADRX] <= RF_DIN;
        end
    end
    assign RF_DX = rf_mem[RF_ADRX];
    assign RF_DY = rf_mem[RF_ADRY];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        A_REQ = 0; A_WE = 0; A_ADDR = '0; A_WDATA = '0;
        B_REQ = 0; B_WE = 0; B_ADDR = '0; B_WDATA = '0;
    endtask

    // Asserts reset with both requesters asking, checks everything is quiet, releases.
    task automatic test_reset(input string tag);
        RST_N = 0;
        A_REQ = 1; B_REQ = 1; A_WE = 1; B_WE = 0;
        #1;
        n_cmp++;
        if ({INIT_DONE, A_GNT, B_GNT, A_RVALID, B_RVALID, A_RDATA, B_RDATA,
             RF_DIN, RF_ADRX, RF_ADRY, RF_WR} !== '0) begin
            n_err++;
            $display("FAIL reset_async_%s: got done=%b gnt=%b%b rv=%b%b rd=%h/%h din=%h x=%h y=%h wr=%b, required all 0",
                     tag, INIT_DONE, A_GNT, B_GNT, A_RVALID, B_RVALID, A_RDATA, B_RDATA,
                     RF_DIN, RF_ADRX, RF_ADRY, RF_WR);
        end
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_cmp++;
        if ({INIT_DONE, A_GNT, B_GNT, A_RVALID, B_RVALID, A_RDATA, B_RDATA,
             RF_DIN, RF_ADRX, RF_ADRY, RF_WR} !== '0) begin
            n_err++;
            $display("FAIL reset_hold_%s: got done=%b gnt=%b%b wr=%b x=%h, required all 0",
                     tag, INIT_DONE, A_GNT, B_GNT, RF_WR, RF_ADRX);
        end
        step();
        idle_inputs();
        RST_N = 1;
    endtask

    // Must be entered right after reset release (just past a rising edge).
    task automatic test_sweep(input logic hold_a);
        A_REQ = hold_a; A_WE = 0; A_ADDR = '0; B_REQ = 0;
        for (int i = 0; i < NR; i++) begin
            @(negedge CLK);
            n_cmp++;
            if ({RF_WR, RF_ADRX, RF_DIN, INIT_DONE, A_GNT, B_GNT} !==
                {1'b1, AW'(i), 8'h00, 1'b0, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL sweep_%0d: got wr=%b x=%0d din=%h done=%b gnt=%b%b, required wr=1 x=%0d din=00 done=0 gnt=00",
                         i, RF_WR, RF_ADRX, RF_DIN, INIT_DONE, A_GNT, B_GNT, i);
            end
            step();
        end
        @(negedge CLK);
        n_cmp++;
        if ({INIT_DONE, A_GNT, RF_WR} !== {1'b1, hold_a, 1'b0}) begin
            n_err++;
            $display("FAIL sweep_end: got done=%b a_gnt=%b wr=%b, required done=1 a_gnt=%b wr=0",
                     INIT_DONE, A_GNT, RF_WR, hold_a);
        end
        step();
        A_REQ = 0;
        if (hold_a) begin
            n_cmp++;
            if ({A_RVALID, A_RDATA} !== {1'b1, 8'h00}) begin
                n_err++;
                $display("FAIL sweep_first_read: got rv=%b rd=%h, required rv=1 rd=00", A_RVALID, A_RDATA);
            end
        end
        for (int i = 0; i < NR; i++) begin
            n_cmp++;
            if (rf_mem[i] !== 8'h00) begin
                n_err++;
                $display("FAIL sweep_clear_%0d: got %h, required 00", i, rf_mem[i]);
            end
        end
    endtask

    task automatic test_write_read();
        A_REQ = 1; A_WE = 1; A_ADDR = 5'd3; A_WDATA = 8'hA5;
        @(negedge CLK);
        n_cmp++;
        if ({A_GNT, RF_WR, RF_ADRX, RF_DIN} !== {1'b1, 1'b1, 5'd3, 8'hA5}) begin
            n_err++;
            $display("FAIL wr_a5: got gnt=%b wr=%b x=%0d din=%h, required 1 1 3 a5", A_GNT, RF_WR, RF_ADRX, RF_DIN);
        end
        step();
        A_WE = 0;
        @(negedge CLK);
        n_cmp++;
        if ({A_GNT, RF_WR, RF_ADRX} !== {1'b1, 1'b0, 5'd3}) begin
            n_err++;
            $display("FAIL rd_issue: got gnt=%b wr=%b x=%0d, required 1 0 3", A_GNT, RF_WR, RF_ADRX);
        end
        step();
        A_REQ = 0;
        n_cmp++;
        if ({A_RVALID, A_RDATA} !== {1'b1, 8'hA5}) begin
            n_err++;
            $display("FAIL rd_return: got rv=%b rd=%h, required rv=1 rd=a5", A_RVALID, A_RDATA);
        end
        step();
        n_cmp++;
        if ({A_RVALID, A_RDATA} !== {1'b0, 8'hA5}) begin
            n_err++;
            $display("FAIL rd_hold: got rv=%b rd=%h, required rv=0 rd=a5", A_RVALID, A_RDATA);
        end
    endtask

    task automatic test_ww_conflict();
        logic [1:0] exp_g;
        A_REQ = 1; A_WE = 1; A_ADDR = 5'd5; A_WDATA = 8'h11;
        B_REQ = 1; B_WE = 1; B_ADDR = 5'd5; B_WDATA = 8'h22;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
            @(negedge CLK);
            n_cmp++;
            if ({A_GNT, B_GNT} !== exp_g) begin
                n_err++;
                $display("FAIL ww_cycle%0d: got gnt=%b%b, required %b", i, A_GNT, B_GNT, exp_g);
            end
            step();
        end
        idle_inputs();
        A_REQ = 1; A_ADDR = 5'd5;
        step();
        A_REQ = 0;
        n_cmp++;
        if ({A_RVALID, A_RDATA} !== {1'b1, 8'h22}) begin
            n_err++;
            $display("FAIL ww_readback: got rv=%b rd=%h, required rv=1 rd=22", A_RVALID, A_RDATA);
        end
    endtask

    task automatic test_write_vs_read();
        A_REQ = 1; A_WE = 1; A_ADDR = 5'd9; A_WDATA = 8'h7F;
        B_REQ = 1; B_WE = 0; B_ADDR = 5'd9;
        @(negedge CLK);
        n_cmp++;
        if ({A_GNT, B_GNT, RF_WR, RF_ADRX, RF_ADRY, RF_DIN} !== {1'b1, 1'b1, 1'b1, 5'd9, 5'd9, 8'h7F}) begin
            n_err++;
            $display("FAIL wvr_issue: got gnt=%b%b wr=%b x=%0d y=%0d din=%h, required 11 1 9 9 7f",
                     A_GNT, B_GNT, RF_WR, RF_ADRX, RF_ADRY, RF_DIN);
        end
        step();
        A_REQ = 0;
        n_cmp++;
        if ({B_RVALID, B_RDATA} !== {1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL wvr_old_value: got rv=%b rd=%h, required rv=1 rd=00", B_RVALID, B_RDATA);
        end
        @(negedge CLK);
        n_cmp++;
        if ({B_GNT, RF_ADRX} !== {1'b1, 5'd9}) begin
            n_err++;
            $display("FAIL wvr_reread_issue: got gnt=%b x=%0d, required 1 9", B_GNT, RF_ADRX);
        end
        step();
        B_REQ = 0;
        n_cmp++;
        if ({B_RVALID, B_RDATA} !== {1'b1, 8'h7F}) begin
            n_err++;
            $display("FAIL wvr_new_value: got rv=%b rd=%h, required rv=1 rd=7f", B_RVALID, B_RDATA);
        end
    endtask

    task automatic test_dual_read();
        idle_inputs();
        A_REQ = 1; A_WE = 1; A_ADDR = 5'd1; A_WDATA = 8'h01;
        step();
        A_ADDR = 5'd2; A_WDATA = 8'h02;
        step();
        A_WE = 0; A_ADDR = 5'd1;
        B_REQ = 1; B_WE = 0; B_ADDR = 5'd2;
        @(negedge CLK);
        n_cmp++;
        if ({A_GNT, B_GNT, RF_WR, RF_ADRX, RF_ADRY} !== {1'b1, 1'b1, 1'b0, 5'd1, 5'd2}) begin
            n_err++;
            $display("FAIL dual_issue: got gnt=%b%b wr=%b x=%0d y=%0d, required 11 0 1 2",
                     A_GNT, B_GNT, RF_WR, RF_ADRX, RF_ADRY);
        end
        step();
        idle_inputs();
        n_cmp++;
        if ({A_RVALID, B_RVALID, A_RDATA, B_RDATA} !== {1'b1, 1'b1, 8'h01, 8'h02}) begin
            n_err++;
            $display("FAIL dual_return: got rv=%b%b rd=%h/%h, required rv=11 rd=01/02",
                     A_RVALID, B_RVALID, A_RDATA, B_RDATA);
        end
    endtask

    task automatic test_reset_mid_sweep();
        test_reset("mid_run");
        repeat (10) step();
        @(negedge CLK);
        n_cmp++;
        if ({RF_WR, RF_ADRX} !== {1'b1, 5'd10}) begin
            n_err++;
            $display("FAIL mid_sweep_pos: got wr=%b x=%0d, required 1 10", RF_WR, RF_ADRX);
        end
        #2;
        RST_N = 0;
        #1;
        n_cmp++;
        if ({INIT_DONE, RF_WR, RF_ADRX, RF_DIN, A_RVALID, B_RVALID} !== '0) begin
            n_err++;
            $display("FAIL mid_sweep_reset: got done=%b wr=%b x=%0d din=%h rv=%b%b, required all 0",
                     INIT_DONE, RF_WR, RF_ADRX, RF_DIN, A_RVALID, B_RVALID);
        end
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1;
        test_sweep(1'b0);
    endtask

    // Random traffic: each requester keeps a pending command until granted.
    task automatic test_random();
        logic [DW-1:0] exp_mem [NR];
        logic          pa, pb, awe, bwe, b_turn, both_w, ga, gb, ra, rb;
        logic [AW-1:0] aad, bad;
        logic [DW-1:0] awd, bwd, last_a, last_b;
        for (int i = 0; i < NR; i++) exp_mem[i] = 8'h00;
        pa = 0; pb = 0; awe = 0; bwe = 0; aad = '0; bad = '0; awd = '0; bwd = '0;
        b_turn = 0; last_a = 8'h00; last_b = 8'h00;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (!pa && $urandom_range(0, 3) != 0) begin
                pa = 1; awe = 1'($urandom_range(0, 1)); aad = 5'($urandom_range(0, 7)); awd = 8'($urandom);
            end
            if (!pb && $urandom_range(0, 3) != 0) begin
                pb = 1; bwe = 1'($urandom_range(0, 1)); bad = 5'($urandom_range(0, 7)); bwd = 8'($urandom);
            end
            A_REQ = pa; A_WE = awe; A_ADDR = aad; A_WDATA = awd;
            B_REQ = pb; B_WE = bwe; B_ADDR = bad; B_WDATA = bwd;

            both_w = pa && awe && pb && bwe;
            if (both_w) begin
                ga = !b_turn; gb = b_turn; b_turn = !b_turn;
            end else begin
                ga = pa; gb = pb;
            end
            ra = ga && !awe;
            rb = gb && !bwe;
            if (ra) last_a = exp_mem[aad];
            if (rb) last_b = exp_mem[bad];
            if (ga && awe) exp_mem[aad] = awd;
            if (gb && bwe) exp_mem[bad] = bwd;

            @(negedge CLK);
            n_cmp++;
            if ({A_GNT, B_GNT} !== {ga, gb}) begin
                n_err++;
                $display("FAIL rand_gnt cyc %0d: got %b%b, required %b%b", cyc, A_GNT, B_GNT, ga, gb);
            end
            if (ga) $display("txn %0d A %s addr=%0d data=%h", cyc, awe ? "wr" : "rd", aad, awe ? awd : last_a);
            if (gb) $display("txn %0d B %s addr=%0d data=%h", cyc, bwe ? "wr" : "rd", bad, bwe ? bwd : last_b);
            step();
            n_cmp++;
            if ({A_RVALID, A_RDATA} !== {ra, last_a}) begin
                n_err++;
                $display("FAIL rand_a_ret cyc %0d: got rv=%b rd=%h, required rv=%b rd=%h", cyc, A_RVALID, A_RDATA, ra, last_a);
            end
            n_cmp++;
            if ({B_RVALID, B_RDATA} !== {rb, last_b}) begin
                n_err++;
                $display("FAIL rand_b_ret cyc %0d: got rv=%b rd=%h, required rv=%b rd=%h", cyc, B_RVALID, B_RDATA, rb, last_b);
            end
            if (ga) pa = 0;
            if (gb) pb = 0;
        end
        idle_inputs();
    endtask

    initial begin
        RST_N = 0;
        idle_inputs();
        step();
        test_reset("initial");
        test_sweep(1'b1);
        test_write_read();
        test_ww_conflict();
        test_write_vs_read();
        test_dual_read();
        test_reset_mid_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
